// File: rtl/integrator_sat_if.sv
// Sample/accumulator bundle for the integrator: control and sample in, result and flags out.
interface integrator_sat_if #(
    parameter int unsigned IN_W  = 10,
    parameter int unsigned ACC_W = 16
);
    logic                    clear;
    logic                    in_valid;
    logic signed [IN_W-1:0]  in_data;
    logic signed [ACC_W-1:0] acc_o;
    logic                    out_valid;
    logic                    ovf_o;

    // Sample source side.
    modport master (
        output clear,
        output in_valid,
        output in_data,
        input  acc_o,
        input  out_valid,
        input  ovf_o
    );

    // Integrator side.
    modport slave (
        input  clear,
        input  in_valid,
        input  in_data,
        output acc_o,
        output out_valid,
        output ovf_o
    );
endinterface

// File: rtl/integrator_sat.sv
// Signed integrator with optional leaky decay, saturating or wrapping overflow handling,
// a sticky overflow flag and a synchronous clear. All outputs are registered.
module integrator_sat #(
    parameter int unsigned IN_W       = 10,
    parameter int unsigned ACC_W      = 16,
    parameter int unsigned SATURATE   = 1,
    parameter int unsigned LEAK_SHIFT = 0
) (
    input  logic             system1000,
    input  logic             system1000_rstn,
    integrator_sat_if.slave  bus
);
    // Two guard bits hold any acc - leak + sample without loss.
    localparam int unsigned EXT_W = ACC_W + 2;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    vld_q, vld_d;
    logic                    ovf_q, ovf_d;

    logic signed [EXT_W-1:0] acc_ext;
    logic signed [EXT_W-1:0] in_ext;
    logic signed [EXT_W-1:0] leak;
    logic signed [EXT_W-1:0] sum;
    logic                    over_hi;
    logic                    over_lo;
    logic signed [ACC_W-1:0] sum_fit;

    // Sign-extend the accumulator and the sample into the guarded width.
    always_comb begin
        acc_ext = {{2{acc_q[ACC_W-1]}}, acc_q};
        in_ext  = {{(EXT_W-IN_W){bus.in_data[IN_W-1]}}, bus.in_data};
    end

    // Leak term: arithmetic shift rounds toward -inf, zero for a pure integrator.
    generate
        if (LEAK_SHIFT == 0) begin : g_no_leak
            always_comb leak = '0;
        end else begin : g_leak
            always_comb leak = acc_ext >>> LEAK_SHIFT;
        end
    endgenerate

    // Candidate sum and out-of-range detection: the bits above the ACC_W sign bit must all
    // agree with the guard sign bit for the result to fit.
    always_comb begin
        sum     = acc_ext - leak + in_ext;
        over_hi = ~sum[EXT_W-1] & (|sum[EXT_W-2:ACC_W-1]);
        over_lo = sum[EXT_W-1] & ~(&sum[EXT_W-2:ACC_W-1]);
        if (SATURATE != 0) begin
            if (over_hi) begin
                sum_fit = ACC_MAX;
            end else if (over_lo) begin
                sum_fit = ACC_MIN;
            end else begin
                sum_fit = sum[ACC_W-1:0];
            end
        end else begin
            sum_fit = sum[ACC_W-1:0];
        end
    end

    // Next-state selection: clear beats an accepted sample, which beats holding.
    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        vld_d = 1'b0;
        if (bus.clear) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (bus.in_valid) begin
            acc_d = sum_fit;
            ovf_d = ovf_q | over_hi | over_lo;
            vld_d = 1'b1;
        end
    end

    // State registers; reset discards the accumulation immediately.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            acc_q <= '0;
            vld_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            vld_q <= vld_d;
            ovf_q <= ovf_d;
        end
    end

    // Registered outputs.
    always_comb begin
        bus.acc_o     = acc_q;
        bus.out_valid = vld_q;
        bus.ovf_o     = ovf_q;
    end
endmodule

// File: tb/tb_integrator_sat.sv
// Bench for integrator_sat: four configurations driven by the same directed stimulus, an
// integer-arithmetic reference model checked every cycle, plus hand-computed expectations.
module tb_integrator_sat;
    localparam int NCFG = 4;

    logic       clk;
    logic       rstn;
    logic       clr;
    logic       vld;
    logic [9:0] din;

    int n_total = 0;
    int n_pass  = 0;

    // Configurations: 0 base 16b sat, 1 12b sat, 2 12b wrap, 3 16b leaky k=2.
    integrator_sat_if #(.IN_W(10), .ACC_W(16)) if_b ();
    integrator_sat_if #(.IN_W(10), .ACC_W(12)) if_s ();
    integrator_sat_if #(.IN_W(10), .ACC_W(12)) if_w ();
    integrator_sat_if #(.IN_W(10), .ACC_W(16)) if_l ();

    assign if_b.clear = clr;  assign if_b.in_valid = vld;  assign if_b.in_data = din;
    assign if_s.clear = clr;  assign if_s.in_valid = vld;  assign if_s.in_data = din;
    assign if_w.clear = clr;  assign if_w.in_valid = vld;  assign if_w.in_data = din;
    assign if_l.clear = clr;  assign if_l.in_valid = vld;  assign if_l.in_data = din;

    integrator_sat #(.IN_W(10), .ACC_W(16), .SATURATE(1), .LEAK_SHIFT(0)) u_base (
        .system1000(clk), .system1000_rstn(rstn), .bus(if_b)
    );
    integrator_sat #(.IN_W(10), .ACC_W(12), .SATURATE(1), .LEAK_SHIFT(0)) u_sat (
        .system1000(clk), .system1000_rstn(rstn), .bus(if_s)
    );
    integrator_sat #(.IN_W(10), .ACC_W(12), .SATURATE(0), .LEAK_SHIFT(0)) u_wrap (
        .system1000(clk), .system1000_rstn(rstn), .bus(if_w)
    );
    integrator_sat #(.IN_W(10), .ACC_W(16), .SATURATE(1), .LEAK_SHIFT(2)) u_leak (
        .system1000(clk), .system1000_rstn(rstn), .bus(if_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    longint dut_acc [NCFG];
    logic   dut_vld [NCFG];
    logic   dut_ovf [NCFG];
    assign dut_acc[0] = longint'(if_b.acc_o);
    assign dut_acc[1] = longint'(if_s.acc_o);
    assign dut_acc[2] = longint'(if_w.acc_o);
    assign dut_acc[3] = longint'(if_l.acc_o);
    assign dut_vld[0] = if_b.out_valid;  assign dut_ovf[0] = if_b.ovf_o;
    assign dut_vld[1] = if_s.out_valid;  assign dut_ovf[1] = if_s.ovf_o;
    assign dut_vld[2] = if_w.out_valid;  assign dut_ovf[2] = if_w.ovf_o;
    assign dut_vld[3] = if_l.out_valid;  assign dut_ovf[3] = if_l.ovf_o;

    function automatic int cfg_w(int i);
        return (i == 1 || i == 2) ? 12 : 16;
    endfunction
    function automatic bit cfg_sat(int i);
        return i != 2;
    endfunction
    function automatic int cfg_k(int i);
        return (i == 3) ? 2 : 0;
    endfunction

    // Reference step in plain integer arithmetic.
    function automatic longint model_step(longint acc, longint x, int w, bit sat, int k,
                                          output bit of);
        longint p, leak, sum, mx, mn, span;
        if (k == 0) begin
            leak = 0;
        end else begin
            p = longint'(1) << k;
            leak = (acc >= 0) ? acc / p : -((-acc + p - 1) / p);
        end
        sum  = acc - leak + x;
        mx   = (longint'(1) << (w - 1)) - 1;
        mn   = -(longint'(1) << (w - 1));
        span = longint'(1) << w;
        of   = (sum > mx) || (sum < mn);
        if (sat) begin
            if (sum > mx) sum = mx;
            if (sum < mn) sum = mn;
        end else begin
            while (sum > mx) sum = sum - span;
            while (sum < mn) sum = sum + span;
        end
        return sum;
    endfunction

    longint m_acc [NCFG] = '{0, 0, 0, 0};
    bit     m_vld [NCFG] = '{0, 0, 0, 0};
    bit     m_ovf [NCFG] = '{0, 0, 0, 0};

    // Reference model state, advanced on the same edges the DUT sees.
    always @(posedge clk or negedge rstn) begin
        bit of;
        for (int i = 0; i < NCFG; i++) begin
            if (!rstn) begin
                m_acc[i] = 0; m_vld[i] = 0; m_ovf[i] = 0;
            end else if (clr) begin
                m_acc[i] = 0; m_vld[i] = 0; m_ovf[i] = 0;
            end else if (vld) begin
                m_acc[i] = model_step(m_acc[i], longint'($signed(din)), cfg_w(i), cfg_sat(i),
                                      cfg_k(i), of);
                m_ovf[i] = m_ovf[i] | of;
                m_vld[i] = 1;
            end else begin
                m_vld[i] = 0;
            end
        end
    end

    task automatic chk(string name, longint got, longint exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    // Cycle-by-cycle comparison of every configuration against the model.
    always @(negedge clk) begin
        for (int i = 0; i < NCFG; i++) begin
            chk($sformatf("model acc[%0d]", i), dut_acc[i], m_acc[i]);
            chk($sformatf("model vld[%0d]", i), longint'(dut_vld[i]), longint'(m_vld[i]));
            chk($sformatf("model ovf[%0d]", i), longint'(dut_ovf[i]), longint'(m_ovf[i]));
        end
    end

    // One cycle of stimulus; returns just after the capturing edge.
    task automatic drive(bit c, bit v, int d);
        @(negedge clk);
        clr = c;
        vld = v;
        din = 10'(d);
        @(posedge clk);
        #1;
    endtask

    task automatic exp_now(string name, int i, longint acc, bit v, bit o);
        chk({name, " acc"}, dut_acc[i], acc);
        chk({name, " vld"}, longint'(dut_vld[i]), longint'(v));
        chk({name, " ovf"}, longint'(dut_ovf[i]), longint'(o));
    endtask

    initial begin
        int basic_in  [4] = '{5, -3, 100, -512};
        int basic_exp [4] = '{5, 2, 102, -410};
        int sat_exp   [5] = '{511, 1022, 1533, 2044, 2047};

        rstn = 1'b0; clr = 1'b0; vld = 1'b0; din = '0;
        repeat (3) @(negedge clk);
        exp_now("reset", 0, 0, 0, 0);
        rstn = 1'b1;

        // Basic integration and a hold gap.
        for (int n = 0; n < 4; n++) begin
            drive(0, 1, basic_in[n]);
            exp_now($sformatf("basic%0d", n), 0, basic_exp[n], 1, 0);
        end
        drive(0, 0, 0);
        exp_now("gap", 0, -410, 0, 0);

        // Saturation (cfg 1) and wrap (cfg 2) from the same 511 stream.
        drive(1, 0, 0);
        for (int n = 0; n < 5; n++) begin
            drive(0, 1, 511);
            exp_now($sformatf("sat%0d", n), 1, sat_exp[n], 1, n == 4);
        end
        exp_now("wrap5", 2, -1541, 1, 1);
        drive(0, 1, -47);
        exp_now("sat_down", 1, 2000, 1, 1);
        repeat (3) drive(0, 1, -512);
        drive(0, 1, -164);
        exp_now("at300", 1, 300, 1, 1);

        // Clear wins over a simultaneous sample.
        drive(1, 1, 7);
        exp_now("clr_prio", 1, 0, 0, 0);
        drive(0, 1, 7);
        exp_now("after_clr", 1, 7, 1, 0);

        // Negative limit: four -512 reach MIN exactly, a fifth saturates.
        drive(1, 0, 0);
        repeat (4) drive(0, 1, -512);
        exp_now("neg4", 1, -2048, 1, 0);
        drive(0, 1, -512);
        exp_now("neg5", 1, -2048, 1, 1);

        // Leaky: +100 settles where floor(acc/4) == 100, reached from below at 400.
        drive(1, 0, 0);
        repeat (40) drive(0, 1, 100);
        for (int n = 0; n < 6; n++) begin
            drive(0, 1, 100);
            chk("leak_pos", dut_acc[3], 400);
        end
        // -100 from zero approaches from above and stops at -397 (floor(-397/4) == -100).
        drive(1, 0, 0);
        repeat (40) drive(0, 1, -100);
        for (int n = 0; n < 6; n++) begin
            drive(0, 1, -100);
            chk("leak_neg", dut_acc[3], -397);
        end

        // Asynchronous reset in the middle of a cycle.
        drive(1, 0, 0);
        drive(0, 1, 37);
        exp_now("pre_rst", 0, 37, 1, 0);
        @(negedge clk);
        vld = 1'b0;
        #2 rstn = 1'b0;
        #1;
        exp_now("async_rst", 0, 0, 0, 0);
        chk("async_rst wrap ovf", longint'(dut_ovf[2]), 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        for (int n = 0; n < 10; n++) begin
            drive(0, 0, 0);
            exp_now("idle", 0, 0, 0, 0);
        end

        @(negedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
